count_sequencer: RTL and testbench

//  Initiator/checker for the simple_soc counter interface: drives the counter's enable and reads back count/match.

---
 rtl/count_sequencer.sv | 85 ++++++++
 tb/tb_count_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: issues N counter enables per command, checks count==base+N; COUNT_SEQ_STATS_EN adds pass/fail totals
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_steps,
    input  logic             req_gap,
    output logic             cnt_enable,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_match,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_pass,
    output logic [WIDTH-1:0] rsp_count,
    output logic             rsp_match
`ifdef COUNT_SEQ_STATS_EN
    ,
    output logic [7:0]       pass_total,
    output logic [7:0]       fail_total
`endif
);
    typedef enum logic [2:0] {IDLE, SNAP, DRIVE, GAP, SETTLE, RESP} state_t;
    state_t state, state_nxt;
    logic live, gap;
    logic [WIDTH-1:0] steps, remaining, base, expect_cnt;
    assign expect_cnt = base + steps;
    assign req_ready  = state == IDLE && live;
    assign cnt_enable = state == DRIVE;
    assign rsp_valid  = state == RESP;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid && req_ready ? SNAP : IDLE;
            SNAP:    state_nxt = steps == '0 ? SETTLE : DRIVE;
            // remaining still holds the pre-decrement value during the last pulse
            DRIVE:   state_nxt = remaining == WIDTH'(1) ? SETTLE : gap ? GAP : DRIVE;
            GAP:     state_nxt = DRIVE;
            SETTLE:  state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            live      <= 1'b0;
            gap       <= 1'b0;
            steps     <= '0;
            remaining <= '0;
            base      <= '0;
            rsp_pass  <= 1'b0;
            rsp_count <= '0;
            rsp_match <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            if (req_valid && req_ready) begin
                steps     <= req_steps;
                remaining <= req_steps;
                gap       <= req_gap;
            end
            if (state == SNAP) base <= cnt_count;
            if (state == DRIVE) remaining <= remaining - 1'b1;
            if (state == SETTLE) begin
                rsp_count <= cnt_count;
                rsp_match <= cnt_match;
                rsp_pass  <= cnt_count == expect_cnt;
            end
        end
    end
`ifdef COUNT_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_total <= '0;
            fail_total <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_pass && pass_total != 8'hff) pass_total <= pass_total + 1'b1;
            if (!rsp_pass && fail_total != 8'hff) fail_total <= fail_total + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: vector table, random commands against an arithmetic model, reset and saturation corners
module tb_count_sequencer;
    typedef struct {
        logic [3:0] steps;
        bit         gap;
        logic [3:0] base;
        bit         stall;
        int         hold;
        logic [3:0] exp_count;
        bit         exp_pass;
        int         exp_lat;
    } vec_t;
    logic clk = 0, reset = 0, req_valid = 0, req_gap = 0, rsp_ready = 0, load = 0, stall = 0;
    logic [3:0] req_steps = 0, load_val = 0, cmp_val = 0, cnt = 0;
    logic req_ready, cnt_enable, rsp_valid, rsp_pass, rsp_match, cnt_match;
    logic [3:0] rsp_count;
`ifdef COUNT_SEQ_STATS_EN
    logic [7:0] pass_total, fail_total;
`endif
    int compared = 0, mismatched = 0, en_seen = 0, b2b = 0;
    int model_pass = 0, model_fail = 0;
    logic prev_en = 0;
    vec_t vecs[7];

    count_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_steps(req_steps), .req_gap(req_gap), .cnt_enable(cnt_enable),
        .cnt_count(cnt), .cnt_match(cnt_match), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_pass(rsp_pass), .rsp_count(rsp_count),
        .rsp_match(rsp_match)
`ifdef COUNT_SEQ_STATS_EN
        , .pass_total(pass_total), .fail_total(fail_total)
`endif
    );

    always #5 clk = ~clk;
    // behavioural counter the sequencer drives; stall models an enable-blocked counter
    assign cnt_match = cnt == cmp_val;
    always @(posedge clk) begin
        if (load) cnt <= load_val;
        else if (cnt_enable && !stall) cnt <= cnt + 1'b1;
        if (cnt_enable) en_seen <= en_seen + 1;
        if (cnt_enable && prev_en) b2b <= b2b + 1;
        prev_en <= cnt_enable;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic stats_chk();
`ifdef COUNT_SEQ_STATS_EN
        chk("pass_total", 32'(pass_total), 32'(model_pass));
        chk("fail_total", 32'(fail_total), 32'(model_fail));
`endif
    endtask

    task automatic run_cmd(input logic [3:0] steps, input bit gap, input logic [3:0] base,
                           input bit stl, input int hold, input logic [3:0] exp_count,
                           input bit exp_pass, input int exp_lat, input string tag);
        int lat, e0, b0;
        logic [3:0] tgt;
        tgt = base + steps;
        @(negedge clk);
        load = 1; load_val = base;
        @(negedge clk);
        load = 0; stall = stl; cmp_val = tgt;
        req_valid = 1; req_steps = steps; req_gap = gap;
        chk({tag, " ready_idle"}, 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_steps = 4'($urandom); req_gap = 1'($urandom);
        e0 = en_seen; b0 = b2b; lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " enables"}, 32'(en_seen - e0), 32'(steps));
        chk({tag, " back_to_back"}, 32'(b2b - b0), gap || steps == 0 ? 0 : 32'(steps) - 1);
        chk({tag, " rsp_count"}, 32'(rsp_count), 32'(exp_count));
        chk({tag, " rsp_pass"}, 32'(rsp_pass), 32'(exp_pass));
        chk({tag, " rsp_match"}, 32'(rsp_match), 32'(exp_count == tgt));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, " hold_ready"}, 32'(req_ready), 0);
            chk({tag, " hold_rsp"}, {rsp_valid, rsp_pass, rsp_match, rsp_count}, {1'b1, exp_pass, exp_count == tgt, exp_count});
        end
        req_valid = 0; rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0; stall = 0;
        if (exp_pass) model_pass = model_pass < 255 ? model_pass + 1 : 255;
        else model_fail = model_fail < 255 ? model_fail + 1 : 255;
        chk({tag, " rsp_done"}, {rsp_valid, req_ready}, 2'b01);
        stats_chk();
    endtask

    initial begin
        int e0, n;
        logic [3:0] s, b, c;
        bit g, st;
        vecs[0] = '{4'd5,  1'b0, 4'd0,  1'b0, 0, 4'd5, 1'b1, 8};
        vecs[1] = '{4'd3,  1'b1, 4'd14, 1'b0, 0, 4'd1, 1'b1, 8};
        vecs[2] = '{4'd0,  1'b0, 4'd9,  1'b0, 0, 4'd9, 1'b1, 3};
        vecs[3] = '{4'd2,  1'b0, 4'd7,  1'b1, 4, 4'd7, 1'b0, 5};
        vecs[4] = '{4'd15, 1'b0, 4'd1,  1'b0, 1, 4'd0, 1'b1, 18};
        vecs[5] = '{4'd15, 1'b1, 4'd3,  1'b0, 0, 4'd2, 1'b1, 32};
        vecs[6] = '{4'd1,  1'b1, 4'd15, 1'b0, 2, 4'd0, 1'b1, 4};
        repeat (3) begin
            @(negedge clk);
            chk("in_reset", {req_ready, cnt_enable, rsp_valid}, 0);
        end
        reset = 1;
        chk("release_ready_low", 32'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset", {req_ready, cnt_enable, rsp_valid, rsp_pass, rsp_match, rsp_count}, 9'b100000000);
        stats_chk();
        foreach (vecs[i])
            run_cmd(vecs[i].steps, vecs[i].gap, vecs[i].base, vecs[i].stall, vecs[i].hold,
                    vecs[i].exp_count, vecs[i].exp_pass, vecs[i].exp_lat, $sformatf("vec%0d", i));
        for (int i = 0; i < 40; i++) begin
            s = 4'($urandom); g = 1'($urandom); b = 4'($urandom); st = $urandom_range(0, 3) == 0;
            c = st ? b : 4'(b + s);
            run_cmd(s, g, b, st, $urandom_range(0, 2), c, c == 4'(b + s),
                    s == 0 ? 3 : g ? 2 * s + 2 : s + 3, $sformatf("rnd%0d", i));
        end
        // abort in the middle of a 6-pulse burst
        @(negedge clk);
        load = 1; load_val = 0;
        @(negedge clk);
        load = 0; req_valid = 1; req_steps = 6; req_gap = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; e0 = en_seen; n = 0;
        while (en_seen - e0 < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_in_drive", 32'(cnt_enable), 1);
        reset = 0;
        #1;
        chk("abort_enable_drop", {cnt_enable, req_ready, rsp_valid}, 0);
        chk("abort_pulses", 32'(cnt), 2);
        repeat (2) @(negedge clk);
        reset = 1; n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("abort_no_rsp", 32'(n), 0);
        chk("abort_idle", {req_ready, rsp_pass, rsp_count}, 6'b100000);
        model_pass = 0; model_fail = 0;
        stats_chk();
`ifdef COUNT_SEQ_STATS_EN
        for (int i = 0; i < 256; i++) run_cmd(0, 0, 4'(i), 0, 0, 4'(i), 1, 3, "sat");
        chk("pass_saturated", 32'(pass_total), 255);
        run_cmd(3, 0, 2, 1, 0, 2, 0, 6, "sat_fail");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
